// File: rtl/ds_pwm_decimator_pkg.sv
// Shared definitions for the ternary pwm link between the beamformer
// modulators and the receive-side decimator.
package ds_pkg;

  // Two-bit ternary code carried on each pwm lane
  typedef logic [1:0] pwm_t;

  localparam pwm_t PWM_POS     = 2'b01;
  localparam pwm_t PWM_NEG     = 2'b11;
  localparam pwm_t PWM_ZERO    = 2'b00;
  localparam pwm_t PWM_ILLEGAL = 2'b10;

  // Map a ternary code to a signed 2-bit value; the illegal code reads as zero
  function automatic logic signed [1:0] pwm_to_int(input pwm_t code);
    case (code)
      PWM_POS:  return 2'sb01;
      PWM_NEG:  return 2'sb11;
      PWM_ZERO: return 2'sb00;
      default:  return 2'sb00;
    endcase
  endfunction

  // Width needed by a sinc2 decimator by DECIM: growth of 2*log2(DECIM) bits
  // on top of a signed input, plus headroom for the +/-DECIM^2 extremes
  function automatic int out_width(input int decim);
    return 2 * $clog2(decim) + 2;
  endfunction

endpackage

// File: rtl/ds_pwm_decimator_if.sv
// Bundle of the pwm input lanes and decimated output bus.
// master: the side feeding pwm codes; slave: the decimator.
interface ds_pwm_decimator_if
  import ds_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DECIM = 8
);

  localparam int OUT_W = out_width(DECIM);

  logic                             en;
  pwm_t [N_CH-1:0]                  pwm;
  logic [N_CH-1:0][OUT_W-1:0]       sample;
  logic                             out_valid;
  logic [N_CH-1:0]                  err;

  modport master (
    output en, pwm,
    input  sample, out_valid, err
  );

  modport slave (
    input  en, pwm,
    output sample, out_valid, err
  );

endinterface

// File: rtl/ds_pwm_decimator_cic2.sv
// One channel of the decimator: ternary decode, two integrators running on
// every enabled input, and two combs that run only on the decimation edge.
module ds_cic2_chan
  import ds_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    dec,
  input  pwm_t                    code,
  output logic signed [OUT_W-1:0] sample,
  output logic                    err
);

  logic signed [1:0]       x_small;
  logic signed [OUT_W-1:0] x;
  logic signed [OUT_W-1:0] int1_q, int1_d;
  logic signed [OUT_W-1:0] int2_q, int2_d;
  logic signed [OUT_W-1:0] d1_q, d1_d;
  logic signed [OUT_W-1:0] d2_q, d2_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic signed [OUT_W-1:0] c1, c2;
  logic                    err_q, err_d;

  // Next-state for integrators, comb delays, output and sticky error;
  // all arithmetic wraps modulo 2^OUT_W by design
  always_comb begin
    x_small  = pwm_to_int(code);
    x        = {{(OUT_W-2){x_small[1]}}, x_small};
    int1_d   = int1_q;
    int2_d   = int2_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    sample_d = sample_q;
    err_d    = err_q;
    if (en) begin
      int1_d = int1_q + x;
      int2_d = int2_q + int1_d;
      if (code == PWM_ILLEGAL) begin
        err_d = 1'b1;
      end
    end
    c1 = int2_d - d1_q;
    c2 = c1 - d2_q;
    if (dec) begin
      d1_d     = int2_d;
      d2_d     = c1;
      sample_d = c2;
    end
  end

  // Channel state registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int1_q   <= '0;
      int2_q   <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      sample_q <= '0;
      err_q    <= 1'b0;
    end else begin
      int1_q   <= int1_d;
      int2_q   <= int2_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      sample_q <= sample_d;
      err_q    <= err_d;
    end
  end

  assign sample = sample_q;
  assign err    = err_q;

endmodule

// File: rtl/ds_pwm_decimator.sv
// N_CH-channel sinc2 decimator for ternary pwm streams. One shared phase
// counter picks the decimation edge so every channel updates together.
module ds_pwm_decimator
  import ds_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DECIM = 8
) (
  input  logic               clock,
  input  logic               reset,
  ds_pwm_decimator_if.slave  bus
);

  localparam int OUT_W = out_width(DECIM);
  localparam int PH_W  = $clog2(DECIM);

  logic [PH_W-1:0]            phase_q, phase_d;
  logic                       valid_q, valid_d;
  logic                       dec_edge;
  logic [N_CH-1:0][OUT_W-1:0] sample_w;
  logic [N_CH-1:0]            err_w;

  assign dec_edge = bus.en && (phase_q == PH_W'(DECIM - 1));

  // Phase advances on enabled inputs only and wraps naturally (DECIM is a
  // power of two); the strobe is raised for the cycle after the last input
  always_comb begin
    phase_d = phase_q;
    valid_d = 1'b0;
    if (bus.en) begin
      phase_d = phase_q + PH_W'(1);
      valid_d = dec_edge;
    end
  end

  // Shared phase counter and output strobe registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    ds_cic2_chan #(
      .OUT_W (OUT_W)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .en     (bus.en),
      .dec    (dec_edge),
      .code   (bus.pwm[g]),
      .sample (sample_w[g]),
      .err    (err_w[g])
    );
  end

  assign bus.sample    = sample_w;
  assign bus.err       = err_w;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_ds_pwm_decimator.sv
// Bench for ds_pwm_decimator: directed scenarios followed by a random run,
// every cycle compared against a triangular-kernel reference model.
module tb_ds_pwm_decimator;

  localparam int N_CH  = 8;
  localparam int DECIM = 8;
  localparam int OUT_W = 2 * $clog2(DECIM) + 2;
  localparam int PW    = 2 * N_CH;
  localparam int SW    = N_CH * OUT_W;

  logic clock = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  ds_pwm_decimator_if #(.N_CH(N_CH), .DECIM(DECIM)) bus ();

  ds_pwm_decimator #(.N_CH(N_CH), .DECIM(DECIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  // Reference model state: raw codes of the last 2*DECIM enabled inputs
  logic [PW-1:0] histQ[$];
  int            phaseCnt;
  logic [SW-1:0] expSample;
  logic          expValid;
  logic [N_CH-1:0] expErr;

  function automatic int decode(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  // sinc2 decimated output = inputs weighted by a triangle 1..DECIM..1,
  // newest input getting weight 1; missing history counts as zero
  function automatic logic [SW-1:0] filterOut();
    logic [SW-1:0] r;
    r = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      int acc;
      acc = 0;
      for (int j = 0; j < 2 * DECIM - 1 && j < histQ.size(); j++) begin
        int w;
        logic [PW-1:0] word;
        w    = (j < DECIM) ? j + 1 : 2 * DECIM - 1 - j;
        word = histQ[histQ.size() - 1 - j];
        acc += w * decode(word[2*ch +: 2]);
      end
      r[ch*OUT_W +: OUT_W] = acc[OUT_W-1:0];
    end
    return r;
  endfunction

  task automatic modelReset();
    histQ.delete();
    phaseCnt  = 0;
    expSample = '0;
    expValid  = 1'b0;
    expErr    = '0;
  endtask

  task automatic checkOutput(input string tag);
    assertCount++;
    assert (bus.out_valid === expValid)
    else begin
      failCount++;
      $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, bus.out_valid, expValid);
    end
    assertCount++;
    assert (bus.sample === expSample)
    else begin
      failCount++;
      $error("[TB] FAIL %s sample: observed %h expected %h", tag, bus.sample, expSample);
    end
    assertCount++;
    assert (bus.err === expErr)
    else begin
      failCount++;
      $error("[TB] FAIL %s err: observed %h expected %h", tag, bus.err, expErr);
    end
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge,
  // compare at the following negedge
  task automatic applyStimulus(input logic enV, input logic [PW-1:0] pwmV, input string tag);
    bus.en  = enV;
    bus.pwm = pwmV;
    @(posedge clock);
    expValid = 1'b0;
    if (enV) begin
      histQ.push_back(pwmV);
      if (histQ.size() > 2 * DECIM) void'(histQ.pop_front());
      for (int ch = 0; ch < N_CH; ch++)
        if (pwmV[2*ch +: 2] == 2'b10) expErr[ch] = 1'b1;
      phaseCnt++;
      if (phaseCnt == DECIM) begin
        phaseCnt  = 0;
        expSample = filterOut();
        expValid  = 1'b1;
      end
    end
    @(negedge clock);
    checkOutput(tag);
  endtask

  task automatic runCycles(input int n, input logic [PW-1:0] w, input bit toggleEn, input string tag);
    for (int i = 0; i < n; i++)
      applyStimulus(toggleEn ? (i % 2 == 0) : 1'b1, w, tag);
  endtask

  task automatic runAlt(input int n, input logic [PW-1:0] a, input logic [PW-1:0] b, input string tag);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, (i % 2 == 0) ? a : b, tag);
  endtask

  task automatic doReset();
    bus.en = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    modelReset();
    checkOutput("reset");
    reset = 1'b0;
  endtask

  task automatic checkConst(input logic [SW-1:0] want, input string tag);
    assertCount++;
    assert (bus.sample === want)
    else begin
      failCount++;
      $error("[TB] FAIL %s const: observed %h expected %h", tag, bus.sample, want);
    end
  endtask

  task automatic checkErrConst(input logic [N_CH-1:0] want, input string tag);
    assertCount++;
    assert (bus.err === want)
    else begin
      failCount++;
      $error("[TB] FAIL %s err_const: observed %h expected %h", tag, bus.err, want);
    end
  endtask

  logic [PW-1:0] allPos, allNeg, allZero, mixed, withIll;
  logic [SW-1:0] c36, c64, cNeg64;

  // Directed scenarios then randomized traffic
  initial begin
    allPos  = {N_CH{2'b01}};
    allNeg  = {N_CH{2'b11}};
    allZero = {N_CH{2'b00}};
    mixed   = {2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01};
    c36     = {N_CH{8'd36}};
    c64     = {N_CH{8'd64}};
    cNeg64  = {N_CH{8'hC0}};

    reset   = 1'b1;
    bus.en  = 1'b0;
    bus.pwm = '0;
    modelReset();
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_init");
    reset = 1'b0;

    $display("[TB] constant +1");
    runCycles(8, allPos, 0, "pos");
    checkConst(c36, "pos_first");
    runCycles(16, allPos, 0, "pos");
    checkConst(c64, "pos_steady");

    $display("[TB] constant -1");
    doReset();
    runCycles(24, allNeg, 0, "neg");
    checkConst(cNeg64, "neg_steady");

    $display("[TB] alternating, zero, mixed channels");
    doReset();
    runAlt(8, allPos, allNeg, "alt");
    checkConst({N_CH{8'd4}}, "alt_first");
    runAlt(16, allPos, allNeg, "alt");
    checkConst('0, "alt_steady");
    doReset();
    runCycles(16, allZero, 0, "zero");
    doReset();
    runCycles(24, mixed, 0, "mixed");

    $display("[TB] en toggling");
    doReset();
    runCycles(48, allPos, 1, "toggle");
    checkConst(c64, "toggle_steady");

    $display("[TB] illegal code");
    doReset();
    runCycles(3, allPos, 0, "ill");
    withIll = allPos;
    withIll[11:10] = 2'b10;
    applyStimulus(1'b1, withIll, "ill_inject");
    checkErrConst(8'h20, "ill_set");
    withIll = allPos;
    withIll[7:6] = 2'b10;
    applyStimulus(1'b0, withIll, "ill_disabled");
    runCycles(12, allPos, 0, "ill_after");
    checkErrConst(8'h20, "ill_sticky");

    $display("[TB] async reset mid-frame");
    doReset();
    runCycles(5, allPos, 0, "async_pre");
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clock);
    reset = 1'b0;
    runCycles(8, allPos, 0, "async_post");
    checkConst(c36, "async_first");
    runCycles(8, allPos, 0, "async_post");

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 600; i++) begin
      logic [PW-1:0] w;
      for (int ch = 0; ch < N_CH; ch++) begin
        case ($urandom_range(0, 30))
          0:              w[2*ch +: 2] = 2'b10;
          1,2,3,4,5,6,7,8,9,10: w[2*ch +: 2] = 2'b01;
          11,12,13,14,15,16,17,18,19,20: w[2*ch +: 2] = 2'b11;
          default:        w[2*ch +: 2] = 2'b00;
        endcase
      end
      applyStimulus($urandom_range(0, 3) != 0, w, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
